// File: rtl/i2c_reg_access_seq.sv
// Sequences Wishbone register accesses to the I2C master core for one single-byte register read or write.
// Each bus access holds stb/cyc until ack and is followed by at least two idle cycles; req_ready is high only in IDLE.
`timescale 1ns/1ps
module i2c_reg_access_seq #(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  localparam logic [4:0] S_INIT0 = 5'd0;
  localparam logic [4:0] S_INIT1 = 5'd1;
  localparam logic [4:0] S_INIT2 = 5'd2;
  localparam logic [4:0] S_IDLE  = 5'd3;
  localparam logic [4:0] S_TXR   = 5'd4;
  localparam logic [4:0] S_CR    = 5'd5;
  localparam logic [4:0] S_POLL  = 5'd6;
  localparam logic [4:0] S_CHK   = 5'd7;
  localparam logic [4:0] S_RXR   = 5'd8;
  localparam logic [4:0] S_RXD   = 5'd9;
  localparam logic [4:0] S_NSTOP = 5'd10;
  localparam logic [4:0] S_NPOLL = 5'd11;
  localparam logic [4:0] S_NCHK  = 5'd12;
  localparam logic [4:0] S_TO    = 5'd13;
  localparam logic [4:0] S_DONE  = 5'd14;
  localparam logic [4:0] S_ACC   = 5'd15;
  localparam logic [4:0] S_GAP   = 5'd16;

  logic [4:0]  state_q, state_d, ret_q, ret_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d, rd_q, rd_d;
  logic        we_q, we_d;
  logic [1:0]  step_q, step_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d, wd_q, wd_d;
  logic [15:0] poll_q, poll_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        acc_go, acc_we;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat, txr_byte, cr_byte;
  logic [4:0]  acc_ret;
  logic [15:0] poll_inc;

  // Step 3 only exists on reads: the data byte has no TXR write.
  always_comb begin
    case (step_q)
      2'd0:    txr_byte = {dev_q, 1'b0};
      2'd1:    txr_byte = reg_q;
      default: txr_byte = rnw_q ? {dev_q, 1'b1} : wd_q;
    endcase
    case (step_q)
      2'd0:    cr_byte = 8'h90;
      2'd1:    cr_byte = 8'h10;
      2'd2:    cr_byte = rnw_q ? 8'h90 : 8'h50;
      default: cr_byte = 8'h68;
    endcase
    poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    rd_d    = rd_q;
    step_d  = step_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    poll_d  = poll_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    acc_go  = 1'b0;
    acc_we  = 1'b0;
    acc_adr = 3'd0;
    acc_dat = 8'h00;
    acc_ret = S_IDLE;

    case (state_q)
      S_INIT0: begin acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd0; acc_dat = PRESCALE[7:0];  acc_ret = S_INIT1; end
      S_INIT1: begin acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; acc_ret = S_INIT2; end
      S_INIT2: begin acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd2; acc_dat = 8'h80;          acc_ret = S_IDLE;  end
      S_IDLE: begin
        if (req_valid) begin
          rnw_d   = req_rnw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wd_d    = req_wdata;
          step_d  = 2'd0;
          err_d   = 2'b00;
          rdata_d = 8'h00;
          state_d = S_TXR;
        end
      end
      S_TXR: begin acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd3; acc_dat = txr_byte; acc_ret = S_CR; end
      S_CR: begin
        acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd4; acc_dat = cr_byte; acc_ret = S_POLL;
        poll_d = 16'd0;
      end
      S_POLL, S_NPOLL: begin
        if (poll_q >= POLL_MAX) begin
          state_d = S_TO;
        end else begin
          acc_go  = 1'b1;
          acc_adr = 3'd4;
          acc_ret = (state_q == S_POLL) ? S_CHK : S_NCHK;
          poll_d  = poll_inc;
        end
      end
      S_CHK: begin
        if (rd_q[1]) begin
          state_d = S_POLL;
        end else if (rd_q[5]) begin
          err_d   = 2'b10;
          state_d = S_DONE;
        end else if (step_q == 2'd3) begin
          state_d = S_RXR;
        end else if (rd_q[7]) begin
          err_d   = 2'b01;
          state_d = S_NSTOP;
        end else if (!rnw_q && step_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = (rnw_q && step_q == 2'd2) ? S_CR : S_TXR;
        end
      end
      S_RXR: begin acc_go = 1'b1; acc_adr = 3'd3; acc_ret = S_RXD; end
      S_RXD: begin rdata_d = rd_q; state_d = S_DONE; end
      S_NSTOP: begin
        acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd4; acc_dat = 8'h40; acc_ret = S_NPOLL;
        poll_d = 16'd0;
      end
      S_NCHK: state_d = rd_q[6] ? S_NPOLL : S_DONE;
      // Disabling the core clears its stuck state before re-initialising.
      S_TO: begin
        acc_go = 1'b1; acc_we = 1'b1; acc_adr = 3'd2; acc_dat = 8'h00; acc_ret = S_DONE;
        err_d  = 2'b11;
      end
      S_DONE: state_d = (err_q == 2'b11) ? S_INIT0 : S_IDLE;
      S_ACC: begin
        if (wbm_ack_i) begin
          rd_d    = wbm_dat_i;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = ret_q;
      default: state_d = S_INIT0;
    endcase

    if (acc_go) begin
      state_d = S_ACC;
      adr_d   = acc_adr;
      dat_d   = acc_dat;
      we_d    = acc_we;
      ret_d   = acc_ret;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_INIT0;
      ret_q   <= S_IDLE;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      we_q    <= 1'b0;
      rd_q    <= 8'h00;
      step_q  <= 2'd0;
      rnw_q   <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'h00;
      wd_q    <= 8'h00;
      poll_q  <= 16'd0;
      err_q   <= 2'b00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      step_q  <= step_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = (state_q == S_ACC);
  assign wbm_cyc_o = (state_q == S_ACC);

endmodule

// File: tb/tb_i2c_reg_access_seq.sv
// Bench for i2c_reg_access_seq: behavioural I2C core + slave model, table vectors, random transactions, corner sequences.
`timescale 1ns/1ps
module tb_i2c_reg_access_seq;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_rnw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0, req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i = '0;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic       wbm_ack_i = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_access_seq #(.PRESCALE(16'd99), .POLL_MAX(16'd4)) dut (
    .clk(clk), .nReset(nReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i)
  );

  int checks = 0;
  int errors = 0;

  // Slave/core scenario, set by the stimulus process only.
  int         txn_id = 0;
  int         nack_at = 0;
  int         al_at = 0;
  bit         stuck = 1'b0;
  logic [7:0] slave_rd = '0;

  // Core + slave model state, owned by the model process.
  logic [2:0] log_adr [0:1023];
  logic [7:0] log_dat [0:1023];
  int log_n = 0, sr_reads = 0, byte_idx = 0, last_txn = -1;
  int tip_left = 0, busy_left = 0, wait_cnt = 0;
  bit rxack = 1'b0, al = 1'b0;

  function automatic int next_byte();
    return (txn_id != last_txn) ? 1 : byte_idx + 1;
  endfunction

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wbm_ack_i <= 1'b0;
      wait_cnt  <= 0;
    end else if (wbm_ack_i) begin
      wbm_ack_i <= 1'b0;
      wait_cnt  <= int'($urandom_range(0, 2));
    end else if (wbm_stb_o && wbm_cyc_o) begin
      if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
      end else begin
        wbm_ack_i <= 1'b1;
        if (wbm_we_o) begin
          log_adr[log_n] <= wbm_adr_o;
          log_dat[log_n] <= wbm_dat_o;
          log_n <= log_n + 1;
          if (wbm_adr_o == 3'd4 && (wbm_dat_o[7] || wbm_dat_o[5] || wbm_dat_o[4])) begin
            last_txn <= txn_id;
            byte_idx <= next_byte();
            tip_left <= int'($urandom_range(0, 2));
            rxack    <= (next_byte() == nack_at);
            al       <= (next_byte() == al_at);
          end else if (wbm_adr_o == 3'd4 && wbm_dat_o[6]) begin
            busy_left <= int'($urandom_range(0, 2));
          end
        end else if (wbm_adr_o == 3'd4) begin
          wbm_dat_i <= {rxack, (busy_left != 0), al, 3'b000, (stuck || tip_left != 0), 1'b0};
          sr_reads  <= sr_reads + 1;
          if (tip_left != 0) tip_left <= tip_left - 1;
          else if (busy_left != 0) busy_left <= busy_left - 1;
        end else begin
          wbm_dat_i <= slave_rd;
        end
      end
    end
  end

  // Bus protocol monitor: stb==cyc, stable address/data while strobed, two quiet cycles after each ack.
  int proto_err = 0;
  int since_ack = 9;
  logic p_stb = 1'b0;
  logic [11:0] p_sig = '0;
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      p_stb     <= 1'b0;
      since_ack <= 9;
    end else begin
      proto_err <= proto_err + int'(wbm_stb_o !== wbm_cyc_o)
                 + int'(p_stb && wbm_stb_o && ({wbm_adr_o, wbm_dat_o, wbm_we_o} !== p_sig))
                 + int'(wbm_stb_o && since_ack < 2);
      p_stb     <= wbm_stb_o;
      p_sig     <= {wbm_adr_o, wbm_dat_o, wbm_we_o};
      since_ack <= wbm_ack_i ? 0 : ((since_ack < 9) ? since_ack + 1 : 9);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [2:0] exp_adr [0:15];
  logic [7:0] exp_dat [0:15];
  int exp_n = 0;

  task automatic exp_push(input logic [2:0] a, input logic [7:0] d);
    exp_adr[exp_n] = a;
    exp_dat[exp_n] = d;
    exp_n++;
  endtask

  // Reference: list of bus writes plus result implied by the transaction rules.
  task automatic ref_txn(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                         input logic [7:0] srd, input int nk, input int alb,
                         output logic [1:0] e, output logic [7:0] rd);
    logic [7:0] tx [4];
    logic [7:0] cr [4];
    exp_n = 0;
    e = 2'b00;
    rd = 8'h00;
    tx[0] = {dev, 1'b0}; tx[1] = rg; tx[2] = rnw ? {dev, 1'b1} : wd; tx[3] = 8'h00;
    cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = rnw ? 8'h90 : 8'h50; cr[3] = 8'h68;
    for (int i = 0; i < (rnw ? 4 : 3); i++) begin
      if (i < 3) exp_push(3'd3, tx[i]);
      exp_push(3'd4, cr[i]);
      if (alb == i + 1) begin e = 2'b10; return; end
      if (nk == i + 1 && i < 3) begin exp_push(3'd4, 8'h40); e = 2'b01; return; end
    end
    if (rnw) rd = srd;
  endtask

  task automatic cmp_log(input string name, input int start);
    int n;
    int bad;
    n = log_n - start;
    bad = -1;
    for (int i = 0; i < exp_n && i < n; i++)
      if (bad < 0 && (log_adr[start+i] !== exp_adr[i] || log_dat[start+i] !== exp_dat[i])) bad = i;
    checks++;
    if (n != exp_n || bad >= 0) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s writes: entry %0d got adr %0d dat %02h want adr %0d dat %02h (count %0d want %0d)",
                 name, bad, log_adr[start+bad], log_dat[start+bad], exp_adr[bad], exp_dat[bad], n, exp_n);
      else
        $display("FAIL %s writes: got count %0d want %0d", name, n, exp_n);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int n = 0; n < 3000 && !req_ready; n++) tick();
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: got req_ready 0 want 1 within 3000 cycles", name);
    end
  endtask

  task automatic run_txn(input string name, input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, output logic [1:0] e, output logic [7:0] rd,
                         output int start, output int srs);
    bit got;
    wait_ready(name);
    txn_id++;
    start = log_n;
    srs = sr_reads;
    req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    req_rnw = 1'($urandom); req_dev = 7'($urandom); req_reg = 8'($urandom); req_wdata = 8'($urandom);
    chk({name, " ready_busy"}, req_ready, 0);
    got = 1'b0;
    e = 2'b00;
    rd = 8'h00;
    for (int n = 0; n < 5000 && !got; n++) begin
      if (rsp_valid) begin got = 1'b1; e = rsp_err; rd = rsp_rdata; end
      else tick();
    end
    srs = sr_reads - srs;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no rsp_valid want pulse within 5000 cycles", name);
    end else begin
      tick();
      chk({name, " rsp_pulse"}, rsp_valid, 0);
    end
  endtask

  typedef struct {
    bit         rnw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] srd;
    int         nk;
    int         alb;
    logic [1:0] exp_err;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [1:0] e, e_exp;
    logic [7:0] rd, rd_exp;
    int start, srs;
    bit rnw;
    logic [6:0] dev;
    logic [7:0] rg, wd;
    int r;

    vecs[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 0, 2'b00, 8'h00};
    vecs[1] = '{1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 0, 0, 2'b00, 8'h5C};
    vecs[2] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 1, 0, 2'b01, 8'h00};
    vecs[3] = '{1'b1, 7'h2A, 8'h07, 8'h00, 8'h33, 0, 1, 2'b10, 8'h00};
    vecs[4] = '{1'b1, 7'h11, 8'hF0, 8'h00, 8'hC3, 4, 0, 2'b00, 8'hC3};
    vecs[5] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, 3, 0, 2'b01, 8'h00};
    vecs[6] = '{1'b1, 7'h50, 8'h80, 8'h00, 8'h99, 3, 0, 2'b01, 8'h00};
    vecs[7] = '{1'b0, 7'h01, 8'h00, 8'h5A, 8'h00, 0, 2, 2'b10, 8'h00};

    repeat (3) tick();
    chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, wbm_adr_o, wbm_dat_o,
                          wbm_we_o, wbm_stb_o, wbm_cyc_o}, 0);
    start = log_n;
    nReset = 1'b1;
    wait_ready("init");
    exp_n = 0;
    exp_push(3'd0, 8'h63); exp_push(3'd1, 8'h00); exp_push(3'd2, 8'h80);
    cmp_log("init", start);
    tick();
    chk("ready_idle", req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      nack_at = vecs[i].nk;
      al_at = vecs[i].alb;
      slave_rd = vecs[i].srd;
      ref_txn(vecs[i].rnw, vecs[i].dev, vecs[i].rg, vecs[i].wd, vecs[i].srd, vecs[i].nk, vecs[i].alb, e_exp, rd_exp);
      run_txn($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].dev, vecs[i].rg, vecs[i].wd, e, rd, start, srs);
      chk($sformatf("vec%0d err", i), e, vecs[i].exp_err);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      cmp_log($sformatf("vec%0d", i), start);
      if (vecs[i].exp_err == 2'b01) chk($sformatf("vec%0d stop_busy_left", i), busy_left, 0);
    end

    for (int k = 0; k < 24; k++) begin
      rnw = 1'($urandom);
      dev = 7'($urandom);
      rg = 8'($urandom);
      wd = 8'($urandom);
      slave_rd = 8'($urandom);
      r = int'($urandom_range(0, 9));
      nack_at = (r < 3) ? int'($urandom_range(1, 4)) : 0;
      al_at = (r == 9) ? int'($urandom_range(1, 4)) : 0;
      ref_txn(rnw, dev, rg, wd, slave_rd, nack_at, al_at, e_exp, rd_exp);
      run_txn($sformatf("rnd%0d", k), rnw, dev, rg, wd, e, rd, start, srs);
      chk($sformatf("rnd%0d err", k), e, e_exp);
      chk($sformatf("rnd%0d rdata", k), rd, rd_exp);
      cmp_log($sformatf("rnd%0d", k), start);
    end

    // Stuck TIP: poll limit, core disable, then a fresh init.
    nack_at = 0;
    al_at = 0;
    stuck = 1'b1;
    run_txn("timeout", 1'b0, 7'h50, 8'h12, 8'hA5, e, rd, start, srs);
    chk("timeout err", e, 2'b11);
    chk("timeout rdata", rd, 0);
    chk("timeout sr_reads", srs, 4);
    wait_ready("timeout_reinit");
    exp_n = 0;
    exp_push(3'd3, 8'hA0); exp_push(3'd4, 8'h90); exp_push(3'd2, 8'h00);
    exp_push(3'd0, 8'h63); exp_push(3'd1, 8'h00); exp_push(3'd2, 8'h80);
    cmp_log("timeout", start);
    stuck = 1'b0;

    // Reset asserted while a read access is strobed.
    wait_ready("midreset");
    txn_id++;
    req_valid = 1'b1; req_rnw = 1'b1; req_dev = 7'h50; req_reg = 8'h34;
    tick();
    req_valid = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (wbm_stb_o && !wbm_we_o) break;
      tick();
    end
    chk("midreset read_strobed", {wbm_stb_o, wbm_we_o}, 2'b10);
    #2 nReset = 1'b0;
    #1;
    chk("midreset outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, wbm_adr_o, wbm_dat_o,
                             wbm_we_o, wbm_stb_o, wbm_cyc_o}, 0);
    start = log_n;
    repeat (2) tick();
    nReset = 1'b1;
    wait_ready("midreset_init");
    exp_n = 0;
    exp_push(3'd0, 8'h63); exp_push(3'd1, 8'h00); exp_push(3'd2, 8'h80);
    cmp_log("midreset_init", start);

    slave_rd = 8'h77;
    ref_txn(1'b1, 7'h3C, 8'h0E, 8'h00, 8'h77, 0, 0, e_exp, rd_exp);
    run_txn("recover", 1'b1, 7'h3C, 8'h0E, 8'h00, e, rd, start, srs);
    chk("recover err", e, e_exp);
    chk("recover rdata", rd, rd_exp);
    cmp_log("recover", start);

    chk("bus_protocol_violations", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
